// File: rtl/tv80_dma_bus_ctrl_if.sv
// Bus-side signals of the tv80 DMA controller: the CPU bus request/acknowledge
// pair and the memory-bus strobes that the top level muxes in when bus_sel=1.
//
// Handshake: the DMA drives busrq_n low to ask for the bus and keeps it low
// for the whole tenure. It treats the bus as granted only when busak_n is
// sampled low at a rising clk edge. It drives the memory strobes only while
// bus_sel=1. To release the bus it raises busrq_n together with bus_sel=0.
// It does not request again until busak_n has been sampled high.
interface tv80_dma_bus_ctrl_if;
  logic        busrq_n;
  logic        busak_n;
  logic        bus_sel;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic [7:0]  dma_di;
  logic        dma_mreq_n;
  logic        dma_rd_n;
  logic        dma_wr_n;

  modport master (
    output busrq_n, bus_sel, dma_a, dma_do, dma_mreq_n, dma_rd_n, dma_wr_n,
    input  busak_n, dma_di
  );

  modport slave (
    input  busrq_n, bus_sel, dma_a, dma_do, dma_mreq_n, dma_rd_n, dma_wr_n,
    output busak_n, dma_di
  );
endinterface

// File: rtl/tv80_dma_bus_ctrl.sv
// Memory-to-memory DMA engine that borrows the tv80s bus via busrq_n/busak_n.
// It copies len bytes from src to dst in strictly ascending order, with 16-bit
// address wrap. After BURST_MAX bytes it returns the bus to the CPU for at
// least GAP_CYCLES clocks before it requests the bus again.
// Optional feature macro: TV80_DMA_FILL_EN adds the fill/fill_val inputs.
// In fill mode the engine writes fill_val to every byte and skips the read
// half of the byte cycle.
// All bus outputs are decoded from the registered state. An async reset
// therefore puts every output back to idle immediately.
module tv80_dma_bus_ctrl #(
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
`ifdef TV80_DMA_FILL_EN
  input  logic        fill,
  input  logic [7:0]  fill_val,
`endif
  output logic        busy,
  output logic        done,
  output logic [3:0]  state_dbg,
  tv80_dma_bus_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_REQ  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_WR1  = 4'd4,
    S_WR2  = 4'd5,
    S_NEXT = 4'd6,
    S_GAP  = 4'd7,
    S_FIN  = 4'd8
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  // burst_cnt holds the number of bytes done before the current NEXT.
  // Comparing it with BURST_MAX-1 means "this byte completes the burst".
  localparam logic [7:0]    BURST_LAST = 8'(BURST_MAX - 1);

  state_t        state_q, state_d;
  logic [15:0]   src_q, dst_q, rem_q;
  logic [7:0]    burst_cnt_q;
  logic [7:0]    data_q;
  logic [GW-1:0] gap_cnt_q;
  logic          gap_done;
  logic          fill_q;
  logic [7:0]    fill_val_q;

  assign state_dbg = state_q;
  assign gap_done  = (gap_cnt_q == GAP_LAST);

`ifdef TV80_DMA_FILL_EN
  // Capture the fill mode and fill byte with the rest of the job on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= 8'h00;
    end else if (state_q == S_IDLE && start && len != 16'd0) begin
      fill_q     <= fill;
      fill_val_q <= fill_val;
    end
  end
`else
  assign fill_q     = 1'b0;
  assign fill_val_q = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: byte sequencing, burst split, and the gap wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (len != 16'd0) ? S_REQ : S_FIN;
      S_REQ:  if (!bus.busak_n) state_d = fill_q ? S_WR1 : S_RD1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_WR1;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = S_NEXT;
      S_NEXT: begin
        if (rem_q == 16'd1)                 state_d = S_FIN;
        else if (burst_cnt_q == BURST_LAST) state_d = S_GAP;
        else                                state_d = fill_q ? S_WR1 : S_RD1;
      end
      S_GAP:  if (gap_done && bus.busak_n) state_d = S_REQ;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: job registers, the read-data latch, and the burst/gap counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= 16'h0000;
      dst_q       <= 16'h0000;
      rem_q       <= 16'h0000;
      burst_cnt_q <= 8'h00;
      data_q      <= 8'h00;
      gap_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && len != 16'd0) begin
            src_q       <= src;
            dst_q       <= dst;
            rem_q       <= len;
            burst_cnt_q <= 8'h00;
          end
        end
        S_RD2:  data_q <= bus.dma_di;
        S_NEXT: begin
          if (!fill_q) src_q <= src_q + 16'd1;
          dst_q       <= dst_q + 16'd1;
          rem_q       <= rem_q - 16'd1;
          burst_cnt_q <= burst_cnt_q + 8'd1;
          gap_cnt_q   <= '0;
        end
        S_GAP: begin
          burst_cnt_q <= 8'h00;
          if (!gap_done) gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode: the bus request, bus ownership, and the memory strobes for each state.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    bus.busrq_n    = 1'b1;
    bus.bus_sel    = 1'b0;
    bus.dma_a      = 16'h0000;
    bus.dma_do     = 8'h00;
    bus.dma_mreq_n = 1'b1;
    bus.dma_rd_n   = 1'b1;
    bus.dma_wr_n   = 1'b1;
    unique case (state_q)
      S_REQ: begin
        busy        = 1'b1;
        bus.busrq_n = 1'b0;
      end
      S_RD1, S_RD2: begin
        busy           = 1'b1;
        bus.busrq_n    = 1'b0;
        bus.bus_sel    = 1'b1;
        bus.dma_a      = src_q;
        bus.dma_mreq_n = 1'b0;
        bus.dma_rd_n   = 1'b0;
      end
      S_WR1, S_WR2: begin
        busy           = 1'b1;
        bus.busrq_n    = 1'b0;
        bus.bus_sel    = 1'b1;
        bus.dma_a      = dst_q;
        bus.dma_do     = fill_q ? fill_val_q : data_q;
        bus.dma_mreq_n = 1'b0;
        bus.dma_wr_n   = 1'b0;
      end
      S_NEXT: begin
        busy        = 1'b1;
        bus.busrq_n = 1'b0;
        bus.bus_sel = 1'b1;
      end
      S_GAP:  busy = 1'b1;
      S_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tv80_dma_bus_ctrl.sv
// Testbench for tv80_dma_bus_ctrl, built with BURST_MAX=2 and GAP_CYCLES=4.
// It models a CPU that grants the bus after a random delay and a 64K memory
// with a negedge-registered read. Expected writes and reads come from a
// byte-by-byte model of the copy. A separate monitor checks every strobe
// against those queues.
module tb_tv80_dma_bus_ctrl;
  localparam int BM = 2;
  localparam int GC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done;
  logic [3:0]  state_dbg;
`ifdef TV80_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [7:0]  fill_val = 8'h00;
`endif

  tv80_dma_bus_ctrl_if bus_if();

  tv80_dma_bus_ctrl #(.BURST_MAX(BM), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src(src), .dst(dst), .len(len),
`ifdef TV80_DMA_FILL_EN
    .fill(fill), .fill_val(fill_val),
`endif
    .busy(busy), .done(done), .state_dbg(state_dbg),
    .bus(bus_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0]  mem       [0:65535];
  logic [7:0]  model_mem [0:65535];
  logic [23:0] exp_q [$];
  logic [15:0] rd_q  [$];
  int errors = 0, checks = 0;
  int tenures = 0, done_cnt = 0, hi_run = 0, cpu_gap_clks = 0;
  int cpu_pc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Memory model: write at posedge while strobed, read registered on negedge.
  initial begin
    bus_if.dma_di = 8'h00;
    fork
      forever begin
        @(posedge clk);
        if (!bus_if.dma_mreq_n && !bus_if.dma_wr_n) mem[bus_if.dma_a] = bus_if.dma_do;
      end
      forever begin
        @(negedge clk);
        if (!bus_if.dma_mreq_n && !bus_if.dma_rd_n) bus_if.dma_di = mem[bus_if.dma_a];
      end
    join
  end

  // CPU model: follows busrq_n with busak_n after 1..3 clocks and runs only while it owns the bus.
  initial begin
    int ak_wait;
    ak_wait = 0;
    bus_if.busak_n = 1'b1;
    forever begin
      @(negedge clk);
      if (bus_if.busak_n) cpu_pc++;
      if (bus_if.busrq_n != bus_if.busak_n) begin
        if (ak_wait == 0) ak_wait = $urandom_range(1, 3);
        ak_wait--;
        if (ak_wait == 0) bus_if.busak_n = bus_if.busrq_n;
      end else begin
        ak_wait = 0;
      end
    end
  end

  // Monitor: check strobes against the scoreboard queues and track tenures, gaps and done pulses.
  initial begin
    logic wr_prev, rd_prev, sel_prev, rq_prev;
    logic [23:0] e;
    logic [15:0] ra;
    wr_prev = 1'b1; rd_prev = 1'b1; sel_prev = 1'b0; rq_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!bus_if.dma_wr_n && wr_prev) begin
          check("wr_owned", {31'd0, bus_if.bus_sel}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write got=%h%h exp=none", bus_if.dma_a, bus_if.dma_do);
          end else begin
            e = exp_q.pop_front();
            check("write", {8'd0, bus_if.dma_a, bus_if.dma_do}, {8'd0, e});
          end
        end
        if (!bus_if.dma_rd_n && rd_prev) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read got=%h exp=none", bus_if.dma_a);
          end else begin
            ra = rd_q.pop_front();
            check("read_addr", {16'd0, bus_if.dma_a}, {16'd0, ra});
          end
        end
        if (bus_if.bus_sel && !sel_prev)
          check("owned_after_ack", {31'd0, bus_if.busak_n}, 32'd0);
        if (!bus_if.busrq_n && rq_prev) begin
          if (tenures > 0) check("gap_len_ge", {31'd0, hi_run >= GC}, 32'd1);
          tenures++;
          hi_run = 0;
        end else if (bus_if.busrq_n) begin
          hi_run++;
        end
        if (done) done_cnt++;
        if (bus_if.busak_n && busy && tenures > 0) cpu_gap_clks++;
      end
      wr_prev = bus_if.dma_wr_n; rd_prev = bus_if.dma_rd_n;
      sel_prev = bus_if.bus_sel; rq_prev = bus_if.busrq_n;
    end
  end

  // Driver: a single copy job. The expected reads and writes come from an ascending byte copy on the model.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input bit poke);
    int exp_ten, n, bad;
    logic [15:0] a, sa;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 16'(i); sa = s + 16'(i);
      model_mem[a] = model_mem[sa];
      rd_q.push_back(sa);
      exp_q.push_back({a, model_mem[a]});
    end
    exp_ten = (int'(l) + BM - 1) / BM;
    tenures = 0; done_cnt = 0; cpu_gap_clks = 0; hi_run = 0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 1'b0; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom_range(1, 9));
    if (l == 16'd0) check("len0_done_next_clk", {31'd0, done}, 32'd1);
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      start = (poke && n == 8) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("busrq_after", {31'd0, bus_if.busrq_n}, 32'd1);
    check("tenures", tenures, exp_ten);
    check("writes_left", exp_q.size(), 0);
    check("reads_left", rd_q.size(), 0);
    bad = 0;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 16'(i);
      if (mem[a] !== model_mem[a]) bad++;
    end
    check("mem_region", bad, 0);
    if (exp_ten > 1) check("cpu_ran_in_gap", {31'd0, cpu_gap_clks > 0}, 32'd1);
    exp_q.delete(); rd_q.delete();
  endtask

`ifdef TV80_DMA_FILL_EN
  // Driver: a fill job. Every destination byte gets v, and no reads are expected.
  task automatic run_fill(input logic [15:0] d, input logic [15:0] l, input logic [7:0] v);
    int n, bad;
    logic [15:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 16'(i);
      model_mem[a] = v;
      exp_q.push_back({a, v});
    end
    tenures = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; dst = d; len = l; fill = 1'b1; fill_val = v; src = 16'($urandom);
    @(negedge clk);
    start = 1'b0; fill = 1'b0;
    n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    check("fill_done_seen", {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
    check("fill_writes_left", exp_q.size(), 0);
    check("fill_reads", rd_q.size(), 0);
    bad = 0;
    for (int i = 0; i < int'(l); i++) if (mem[d + 16'(i)] !== v) bad++;
    check("fill_mem_region", bad, 0);
    exp_q.delete();
  endtask
`endif

  // Main sequence.
  initial begin
    int n, p;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33; mem[16'h1003] = 8'h44;
    for (int i = 0; i < 4; i++) model_mem[16'h1000 + i] = mem[16'h1000 + i];

    #2;
    check("rst_ctrl", {28'd0, busy, done, bus_if.busrq_n, bus_if.bus_sel}, 32'b0010);
    check("rst_bus", {5'd0, bus_if.dma_a, bus_if.dma_do, bus_if.dma_mreq_n, bus_if.dma_rd_n, bus_if.dma_wr_n},
          {5'd0, 16'h0000, 8'h00, 3'b111});
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_copy(16'h1000, 16'h2000, 16'd4, 1'b0);
    check("copy_byte0", {24'd0, mem[16'h2000]}, 32'h11);
    check("copy_byte3", {24'd0, mem[16'h2003]}, 32'h44);
    run_copy(16'h1100, 16'h2100, 16'd5, 1'b1);
    run_copy(16'h1200, 16'h2200, 16'd0, 1'b0);
    run_copy(16'hFFFE, 16'h0010, 16'd4, 1'b0);
    run_copy(16'h3000, 16'h3002, 16'd6, 1'b0);
    for (int k = 0; k < 6; k++)
      run_copy(16'($urandom), 16'($urandom), 16'($urandom_range(1, 9)), 1'b0);
`ifdef TV80_DMA_FILL_EN
    run_fill(16'h3000, 16'd3, 8'hA5);
`endif

    // An async reset in the middle of a long copy must drop the bus at once.
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back({16'h5000 + 16'(i), model_mem[16'h4000 + i]});
      rd_q.push_back(16'h4000 + 16'(i));
    end
    @(negedge clk);
    start = 1'b1; src = 16'h4000; dst = 16'h5000; len = 16'd100;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 90 && n < 3000) begin @(negedge clk); n++; end
    check("ten_bytes_before_reset", {31'd0, exp_q.size() <= 90}, 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {28'd0, busy, done, bus_if.busrq_n, bus_if.bus_sel}, 32'b0010);
    check("midrst_strobes", {29'd0, bus_if.dma_mreq_n, bus_if.dma_rd_n, bus_if.dma_wr_n}, 32'b111);
    exp_q.delete(); rd_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!bus_if.busak_n && n < 20) begin @(negedge clk); n++; end
    check("cpu_resumed", {31'd0, bus_if.busak_n}, 32'd1);
    p = cpu_pc;
    repeat (5) @(negedge clk);
    check("cpu_pc_advances", {31'd0, cpu_pc > p}, 32'd1);
    check("idle_after_reset", {28'd0, state_dbg}, 32'd0);
    run_copy(16'h6000, 16'h7000, 16'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
